// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared FSM state type and ns-to-cycle conversion for the WS2812 streamer
package ws2812_pkg;

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  // floor(hz * ns / 1e9) in 64-bit so large clocks times long latch times cannot overflow
  function automatic longint unsigned ns2cyc(input longint unsigned hz, input longint unsigned ns);
    return hz * ns / 64'd1_000_000_000;
  endfunction

endpackage

// File: rtl/ws2812_bitcell.sv
// ws2812_bitcell: one WS2812 bit cell generator; start is held high to run cells back to back
module ws2812_bitcell #(
  parameter int N_CELL = 31,
  parameter int N0H = 10,
  parameter int N1H = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic start,
  output logic led_o,
  output logic cell_last
);

  localparam int CW = $clog2(N_CELL + 1);

  logic [CW-1:0] cnt;

  assign cell_last = start && cnt == CW'(N_CELL - 1);

  // position within the current cell; parked at zero while idle so the first cell starts clean
  always_ff @(posedge clk)
    cnt <= (reset || !start || cell_last) ? '0 : cnt + CW'(1);

  // line is high for the first NxH cycles of each cell, chosen by the bit being sent
  always_ff @(posedge clk)
    led_o <= !reset && start && cnt < CW'(bit_in ? N1H : N0H);

endmodule

// File: rtl/ws2812_stream.sv
// ws2812_stream: pixel stream to WS2812 serial line; optional WS2812_BRIGHTNESS_EN adds brightness scaling
module ws2812_stream
  import ws2812_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000,
  parameter int LED_CNT = 8,
  parameter int CHANNELS = 3,
  parameter int BPC = 8,
  parameter int T_CELL_NS = 1250,
  parameter int T0H_NS = 400,
  parameter int T1H_NS = 800,
  parameter int T_LATCH_NS = 50000
) (
  input  logic clk,
  input  logic reset,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0] brightness,
`endif
  input  logic [CHANNELS*BPC-1:0] pix_data,
  input  logic pix_valid,
  output logic pix_ready,
  output logic led_o,
  output logic busy,
  output logic frame_done,
  output logic underrun
);

  localparam int W = CHANNELS * BPC;
  localparam int N_CELL = int'(ns2cyc(64'(CLK_HZ), 64'(T_CELL_NS)));
  localparam int N0H = int'(ns2cyc(64'(CLK_HZ), 64'(T0H_NS)));
  localparam int N1H = int'(ns2cyc(64'(CLK_HZ), 64'(T1H_NS)));
  localparam int N_LATCH = int'(ns2cyc(64'(CLK_HZ), 64'(T_LATCH_NS)));
  localparam int BW = $clog2(W + 1);
  localparam int PW = $clog2(LED_CNT + 1);
  localparam int LW = $clog2(N_LATCH + 1);

  state_t state;
  logic [W-1:0] hold, shift, load;
  logic hold_full, accept, cell_last, px_last, load_now;
  logic [BW-1:0] bit_cnt;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] lat_cnt;

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [W-1:0] scale(input logic [W-1:0] px, input logic [7:0] b);
    logic [W-1:0] r;
    logic [BPC+8:0] p;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      p = (BPC+9)'(px[c*BPC +: BPC]) * (BPC+9)'({1'b0, b} + 9'd1);
      r[c*BPC +: BPC] = p[BPC+7:8];
    end
    return r;
  endfunction
  assign load = scale(hold, brightness);
`else
  assign load = hold;
`endif

  assign pix_ready = !hold_full && state != LATCH;
  assign busy = state != IDLE;
  assign accept = pix_valid && pix_ready;
  assign px_last = cell_last && bit_cnt == BW'(W - 1);
  // a frame starts from a full holding register, and each pixel boundary refills the shifter if more pixels are due
  assign load_now = hold_full && ((state == IDLE) || (px_last && pix_cnt != PW'(LED_CNT)));

  ws2812_bitcell #(.N_CELL(N_CELL), .N0H(N0H), .N1H(N1H)) u_cell (
    .clk(clk),
    .reset(reset),
    .bit_in(shift[W-1]),
    .start(state == SEND),
    .led_o(led_o),
    .cell_last(cell_last)
  );

  // holding/shift datapath plus the IDLE/SEND/LATCH controller with its one-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold <= '0;
      hold_full <= 1'b0;
      shift <= '0;
      bit_cnt <= '0;
      pix_cnt <= '0;
      lat_cnt <= '0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun <= 1'b0;
      if (accept) hold <= pix_data;
      hold_full <= accept || (hold_full && !load_now);
      shift <= load_now ? load : cell_last ? shift << 1 : shift;
      bit_cnt <= (load_now || px_last) ? '0 : bit_cnt + BW'(cell_last);
      case (state)
        IDLE: begin
          if (hold_full) begin
            state <= SEND;
            pix_cnt <= PW'(1);
          end
        end
        SEND: begin
          if (px_last && load_now) pix_cnt <= pix_cnt + PW'(1);
          else if (px_last) begin
            state <= LATCH;
            underrun <= pix_cnt != PW'(LED_CNT);
          end
        end
        LATCH: begin
          lat_cnt <= lat_cnt + LW'(1);
          if (lat_cnt == LW'(N_LATCH - 1)) begin
            state <= IDLE;
            lat_cnt <= '0;
            pix_cnt <= '0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_stream.sv
// tb_ws2812_stream: waveform-level checks of ws2812_stream against an arithmetic cell/frame model
module tb_ws2812_stream;

  localparam int LED_CNT = 2;
  localparam int NC = 31;
  localparam int N0 = 10;
  localparam int N1 = 20;
  localparam int NL = 1250;
  localparam int MAXS = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_valid = 1'b0;
  logic [23:0] pix_data = 24'h0;
  logic pix_ready, led_o, busy, frame_done, underrun;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] brightness = 8'd0;
`endif

  always #20 clk = ~clk;

  ws2812_stream #(.LED_CNT(LED_CNT)) dut (
    .clk(clk),
    .reset(reset),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .led_o(led_o),
    .busy(busy),
    .frame_done(frame_done),
    .underrun(underrun)
  );

  typedef struct {
    logic [23:0] p0;
    logic [23:0] p1;
    int np;
    int ur;
    int fd_off;
  } vec_t;

  int total = 0;
  int bad = 0;
  int n = 0;
  int acc_edge[$];
  logic [23:0] q[$];
  logic rec_led[MAXS], rec_fd[MAXS], rec_ur[MAXS], rec_busy[MAXS], rec_rdy[MAXS];
  logic exp_led[MAXS], exp_fd[MAXS], exp_ur[MAXS], exp_busy[MAXS];
  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  function automatic logic [23:0] bscale(input logic [23:0] p, input logic [7:0] b);
    logic [23:0] r;
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'((int'(p[c*8 +: 8]) * (int'(b) + 1)) / 256);
    return r;
  endfunction

  function automatic logic [23:0] sc(input logic [23:0] p);
`ifdef WS2812_BRIGHTNESS_EN
    return bscale(p, brightness);
`else
    return p;
`endif
  endfunction

  // one clock: handshake bookkeeping, then sample outputs at the falling edge
  task automatic step();
    logic acc;
    acc = pix_valid && pix_ready;
    @(posedge clk);
    @(negedge clk);
    n++;
    if (acc) begin
      acc_edge.push_back(n);
      void'(q.pop_front());
    end
    pix_valid = q.size() > 0;
    pix_data = q.size() > 0 ? q[0] : 24'h0;
    if (n < MAXS) begin
      rec_led[n] = led_o;
      rec_fd[n] = frame_done;
      rec_ur[n] = underrun;
      rec_busy[n] = busy;
      rec_rdy[n] = pix_ready;
    end
  endtask

  task automatic push(input logic [23:0] p);
    q.push_back(p);
    pix_valid = 1'b1;
    pix_data = q[0];
  endtask

  task automatic run_to(input int target);
    while (n < target && n < MAXS - 1) step();
  endtask

  task automatic do_reset();
    q.delete();
    pix_valid = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    n = 0;
    acc_edge.delete();
    for (int k = 0; k < MAXS; k++) begin
      exp_led[k] = 0; exp_fd[k] = 0; exp_ur[k] = 0; exp_busy[k] = 0;
      rec_led[k] = 0; rec_fd[k] = 0; rec_ur[k] = 0; rec_busy[k] = 0; rec_rdy[k] = 0;
    end
`ifdef WS2812_BRIGHTNESS_EN
    brightness = 8'($urandom);
`endif
  endtask

  task automatic wait_accept(input string nm, output int e);
    int b;
    b = 0;
    while (acc_edge.size() == 0 && b < 20) begin
      step();
      b++;
    end
    if (acc_edge.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s accept timeout: got none want 1", nm);
      e = 0;
    end else e = acc_edge[0];
  endtask

  // expected line: cells start at s, each NC cycles, high N1/N0 by bit (MSB first), then latch
  task automatic add_frame(input int s, input logic [23:0] p0, input logic [23:0] p1,
                           input int np, output int fd);
    int nc, last;
    logic [23:0] px;
    nc = 24 * np;
    for (int j = 0; j < nc; j++) begin
      px = j < 24 ? p0 : p1;
      for (int m = 0; m < NC; m++) exp_led[s + NC*j + m] = m < (px[23 - j % 24] ? N1 : N0);
    end
    last = s - 1 + NC * nc;
    exp_ur[last] = np < LED_CNT;
    fd = last + NL;
    exp_fd[fd] = 1;
    for (int k = s - 1; k < fd; k++) exp_busy[k] = 1;
  endtask

  task automatic cmp_wave(input string nm);
    int kl, kf, ku, kb;
    kl = n; kf = n; ku = n; kb = n;
    for (int k = n; k >= 1; k--) begin
      if (rec_led[k] !== exp_led[k]) kl = k;
      if (rec_fd[k] !== exp_fd[k]) kf = k;
      if (rec_ur[k] !== exp_ur[k]) ku = k;
      if (rec_busy[k] !== exp_busy[k]) kb = k;
    end
    chk($sformatf("%s led@%0d", nm, kl), 32'(rec_led[kl]), 32'(exp_led[kl]));
    chk($sformatf("%s frame_done@%0d", nm, kf), 32'(rec_fd[kf]), 32'(exp_fd[kf]));
    chk($sformatf("%s underrun@%0d", nm, ku), 32'(rec_ur[ku]), 32'(exp_ur[ku]));
    chk($sformatf("%s busy@%0d", nm, kb), 32'(rec_busy[kb]), 32'(exp_busy[kb]));
  endtask

  initial begin
    int e, fd, fd2, k, cnt;
    logic [23:0] p[4];
    tbl[0] = '{24'h800000, 24'h000000, 1, 1, 1995};
    tbl[1] = '{24'hFFFFFF, 24'h000000, 2, 0, 2739};
    tbl[2] = '{24'hA5A5A5, 24'h5A5A5A, 2, 0, 2739};
    tbl[3] = '{24'h000001, 24'h000000, 1, 1, 1995};
    tbl[4] = '{24'($urandom), 24'($urandom), 2, 0, 2739};
    tbl[5] = '{24'($urandom), 24'h000000, 1, 1, 1995};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      chk($sformatf("v%0d reset state", i), int'({led_o, busy, frame_done, underrun, pix_ready}), 1);
      push(tbl[i].p0);
      if (tbl[i].np == 2) push(tbl[i].p1);
      wait_accept($sformatf("v%0d", i), e);
      run_to(e + tbl[i].fd_off + 40);
      chk($sformatf("v%0d accepted", i), acc_edge.size(), tbl[i].np);
      k = -1;
      cnt = 0;
      for (int j = n; j > e; j--) if (rec_fd[j]) k = j;
      for (int j = 1; j <= n; j++) cnt += int'(rec_ur[j]);
      chk($sformatf("v%0d done offset", i), k - e, tbl[i].fd_off);
      chk($sformatf("v%0d underrun pulses", i), cnt, tbl[i].ur);
      add_frame(e + 2, sc(tbl[i].p0), sc(tbl[i].p1), tbl[i].np, fd);
      cmp_wave($sformatf("v%0d", i));
    end

    // continuous valid: third pixel waits out the latch and opens the next frame
    do_reset();
    for (int j = 0; j < 4; j++) begin
      p[j] = 24'($urandom);
      push(p[j]);
    end
    wait_accept("stream", e);
    add_frame(e + 2, sc(p[0]), sc(p[1]), 2, fd);
    add_frame(fd + 2, sc(p[2]), sc(p[3]), 2, fd2);
    run_to(fd2 + 40);
    chk("stream accepted", acc_edge.size(), 4);
    cnt = 0;
    for (int j = fd - NL; j < fd; j++) cnt += int'(rec_rdy[j]);
    chk("stream ready in latch", cnt, 0);
    k = -1;
    for (int j = n; j > fd; j--) if (rec_led[j]) k = j;
    chk("stream restart gap", k - fd, 2);
    cmp_wave("stream");

    // second pixel arriving on the last possible edge versus one edge too late
    for (int late = 0; late < 2; late++) begin
      do_reset();
      p[0] = 24'($urandom);
      p[1] = 24'($urandom);
      push(p[0]);
      wait_accept("feed", e);
      run_to(e + 743 + late);
      push(p[1]);
      if (late == 0) begin
        add_frame(e + 2, sc(p[0]), sc(p[1]), 2, fd);
        run_to(fd + 40);
      end else begin
        add_frame(e + 2, sc(p[0]), 24'h0, 1, fd);
        add_frame(fd + 2, sc(p[1]), 24'h0, 1, fd2);
        run_to(fd2 + 40);
      end
      chk($sformatf("feed%0d second accept", late), acc_edge.size() > 1 ? acc_edge[1] - e : -1, 744 + late);
      cmp_wave($sformatf("feed%0d", late));
    end

    // reset in cell 5 of pixel 1 with the next pixel already held
    do_reset();
    push(24'hFFFFFF);
    push(24'h123456);
    wait_accept("midreset", e);
    run_to(e + 2 + NC*5 + 3);
    chk("midreset led before", 32'(led_o), 1);
    reset = 1'b1;
    step();
    chk("midreset outputs", int'({led_o, busy, pix_ready, frame_done, underrun}), 4);
    reset = 1'b0;
    k = n;
    run_to(k + 200);
    cnt = 0;
    for (int j = k + 1; j <= n; j++) cnt += int'(rec_led[j]) + int'(rec_busy[j]);
    chk("midreset stays idle", cnt, 0);

`ifdef WS2812_BRIGHTNESS_EN
    do_reset();
    brightness = 8'd127;
    push(24'hFF8040);
    wait_accept("bright", e);
    add_frame(e + 2, 24'h7F4020, 24'h0, 1, fd);
    run_to(fd + 40);
    cmp_wave("bright");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws2812_stream.md
WS2812_STREAM -- requirements
Module: ws2812_stream

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter LED_CNT, default 8, pixels per frame (>=1).
REQ-003 SHALL have parameter CHANNELS, default 3, colour channels per pixel.
REQ-004 SHALL have parameter BPC, default 8, bits per channel.
REQ-005 SHALL have parameter T_CELL_NS, default 1250, bit-cell period in ns.
REQ-006 SHALL have parameter T0H_NS, default 400, high time of a '0' bit in ns.
REQ-007 SHALL have parameter T1H_NS, default 800, high time of a '1' bit in ns.
REQ-008 SHALL have parameter T_LATCH_NS, default 50000, low latch time after a frame in ns.
REQ-009 SHALL have port clk, input, 1, rising-edge clock.
REQ-010 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-011 SHALL have port pix_data, input, CHANNELS*BPC, pixel; MSB sent first.
REQ-012 SHALL have port pix_valid, input, 1, pix_data valid.
REQ-013 SHALL have port pix_ready, output, 1, pixel accepted when pix_valid && pix_ready at a clock edge.
REQ-014 SHALL have port led_o, output, 1, registered serial line.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-016 SHALL have port frame_done, output, 1, one-cycle pulse on LATCH exit.
REQ-017 SHALL have port underrun, output, 1, one-cycle pulse on mid-frame starvation.

Function
REQ-018 SHALL derive cycle counts as floor(CLK_HZ*T_x_NS/1e9), computed in 64-bit integer arithmetic at elaboration: N_CELL, N0H, N1H, N_LATCH.
REQ-019 SHALL contain a one-entry holding register plus a shift register; pix_ready = !hold_full && state!=LATCH.
REQ-020 SHALL use states IDLE, SEND, LATCH; IDLE->SEND when holding is full; SEND->LATCH after the last cell of pixel LED_CNT or on underrun; LATCH->IDLE after N_LATCH cycles.
REQ-021 SHALL, for acceptance at edge E in IDLE, load the shift register at E+1 and drive led_o high from E+2.
REQ-022 SHALL drive led_o high for cycles 0..NxH-1 of each N_CELL-cycle cell (NxH per the bit value), low for the remainder.
REQ-023 SHALL transfer holding to shift on the last cycle of a pixel's last cell, so consecutive pixels are gap-free.
REQ-024 SHALL, if holding is empty at that point with pixel count < LED_CNT, pulse underrun, hold led_o low, and enter LATCH.
REQ-025 SHALL accept a pixel during SEND concurrently with the holding->shift transfer (no lost or duplicated pixel).
REQ-026 SHALL count pixels with a $clog2(LED_CNT+1)-bit counter, cleared on entering IDLE.
REQ-027 SHALL keep led_o low in IDLE and LATCH.

Reset
REQ-028 SHALL, on reset, set led_o=0, busy=0, frame_done=0, underrun=0, pix_ready=1, state=IDLE, all counters 0, and holding empty, effective the cycle after the reset edge, including mid-frame.

Configuration
REQ-029 SHALL, with WS2812_BRIGHTNESS_EN defined, add input brightness[7:0] and load each channel as (c*(brightness+1))>>8, truncated to BPC bits, at shift-register load.
REQ-030 SHALL, without WS2812_BRIGHTNESS_EN, omit the brightness port and send data unmodified.

Structure
REQ-031 SHALL place the state enum and the ns-to-cycles function in package ws2812_pkg.
REQ-032 SHALL implement cell timing in sub-module ws2812_bitcell (bit in, start, led_o, cell_last).

Verification (CLK_HZ=25e6: N_CELL=31, N0H=10, N1H=20, N_LATCH=1250; LED_CNT=2)
REQ-033 SHALL check: one pixel 0x800000, then none -> first cell high 20 cycles, next 23 cells high 10 cycles, then underrun pulse and 1250 low cycles.
REQ-034 SHALL check: pixels 0xFFFFFF, 0x000000 back-to-back -> 48 contiguous cells (24x20-high, 24x10-high), frame_done 1250 cycles after the last cell.
REQ-035 SHALL check: pix_valid held high continuously -> pix_ready low throughout LATCH, a third pixel starts a new frame directly after frame_done.
REQ-036 SHALL check: reset asserted in cell 5 of pixel 1 -> led_o=0, busy=0, pix_ready=1 the next cycle.
REQ-037 SHALL check: WS2812_BRIGHTNESS_EN, brightness=127, pixel 0xFF8040 -> transmitted 0x7F4020.
